// File: rtl/serial_addsub_if.sv
// serial_addsub_if: operand/request and result/status bundle for the bit-serial adder/subtractor.
interface serial_addsub_if #(parameter int WIDTH = 8);
   logic             en;
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;
   logic             done;
   modport master (output en, start, sub, cin, a, b, input sum, cout, ovf, busy, done);
   modport slave  (input en, start, sub, cin, a, b, output sum, cout, ovf, busy, done);
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first bit-serial adder/subtractor, one full-adder step per enabled clock.
module serial_addsub #(parameter int WIDTH = 8) (
   input logic           clk,
   input logic           rst,
   serial_addsub_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, r_q, sum_q, r_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, ovf_q, busy_q, done_q;
   logic             s_d, carry_d, last;
   assign s_d     = a_q[0] ^ b_q[0] ^ carry_q;
   assign carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
   assign r_d     = {s_d, r_q[WIDTH-1:1]};
   assign last    = cnt_q == CW'(WIDTH - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.sub ? ~bus.b : bus.b;
                  carry_q <= bus.sub | bus.cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end else begin
                  state_q <= IDLE;
               end
            end
            SHIFT: if (bus.en) begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= carry_d;
               r_q     <= r_d;
               cnt_q   <= cnt_q + CW'(1);
               // carry_q here is the carry into the MSB, carry_d the carry out of it
               if (last) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  sum_q   <= r_d;
                  cout_q  <= carry_d;
                  ovf_q   <= carry_q ^ carry_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed scoreboard bench for serial_addsub at WIDTH=8 and WIDTH=3.
module tb_serial_addsub;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   serial_addsub_if #(.WIDTH(8)) u ();
   serial_addsub_if #(.WIDTH(3)) u3 ();
   serial_addsub #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(u));
   serial_addsub #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(u3));
   typedef struct packed {logic [7:0] s; logic c; logic o;} exp_t;
   exp_t       q[$];
   int         vecs = 0;
   int         errs = 0;
   logic [7:0] last_sum = 8'h00;
   bit         hold = 1'b0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vecs++;
      assert (obs === exp_v) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask
   task automatic push_op(input logic [7:0] a, input logic [7:0] b, input bit cin, input bit sub);
      logic [7:0] bb;
      logic [8:0] t;
      bb = sub ? ~b : b;
      t = {1'b0, a} + {1'b0, bb} + 9'(sub ? 1'b1 : cin);
      q.push_back('{s: t[7:0], c: t[8], o: (a[7] == bb[7]) && (t[7] != a[7])});
      u.a = a;
      u.b = b;
      u.cin = cin;
      u.sub = sub;
      u.start = 1'b1;
   endtask
   task automatic run(input int div, input bit inject, input int exp_cyc, input string tag);
      int   en_n = 0;
      int   cyc = 0;
      bit   got = 1'b0;
      bit   stable = 1'b1;
      exp_t e;
      @(negedge clk);
      if (!hold) u.start = 1'b0;
      chk({tag, " busy_after_load"}, 32'(u.busy), 1);
      for (int c = 1; c <= 100 && !got; c++) begin
         u.en = (div <= 1) || (c % div == 0);
         if (inject && c == 3) begin
            u.start = 1'b1;
            u.a = 8'hFF;
            u.b = 8'hFF;
            u.sub = 1'b1;
         end
         if (inject && c == 4) u.start = 1'b0;
         @(negedge clk);
         if (u.en) en_n++;
         if (u.done) begin
            got = 1'b1;
            cyc = c;
         end else if (u.sum !== last_sum || u.busy !== 1'b1) begin
            stable = 1'b0;
         end
      end
      u.en = 1'b1;
      chk({tag, " done_seen"}, 32'(got), 1);
      chk({tag, " stable_in_shift"}, 32'(stable), 1);
      if (got) begin
         e = q.pop_front();
         chk({tag, " sum"}, 32'(u.sum), 32'(e.s));
         chk({tag, " cout"}, 32'(u.cout), 32'(e.c));
         chk({tag, " ovf"}, 32'(u.ovf), 32'(e.o));
         chk({tag, " busy_at_done"}, 32'(u.busy), 0);
         chk({tag, " enabled_edges"}, 32'(en_n), 8);
         chk({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
         last_sum = e.s;
      end
   endtask
   initial begin
      bit nd = 1'b0;
      bit g3 = 1'b0;
      int cyc3 = 0;
      u.en = 1'b1; u.start = 1'b0; u.sub = 1'b0; u.cin = 1'b0; u.a = '0; u.b = '0;
      u3.en = 1'b1; u3.start = 1'b0; u3.sub = 1'b0; u3.cin = 1'b0; u3.a = '0; u3.b = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset sum", 32'(u.sum), 0);
      chk("reset cout", 32'(u.cout), 0);
      chk("reset ovf", 32'(u.ovf), 0);
      chk("reset busy", 32'(u.busy), 0);
      chk("reset done", 32'(u.done), 0);
      rst = 1'b0;
      @(negedge clk);
      push_op(8'h5A, 8'h3C, 1'b0, 1'b0); run(1, 1'b0, 8, "add_5a_3c");
      @(negedge clk);
      chk("done_one_cycle", 32'(u.done), 0);
      push_op(8'hFF, 8'h01, 1'b0, 1'b0); run(1, 1'b0, 8, "wrap_ff_01");
      @(negedge clk);
      push_op(8'h7F, 8'h00, 1'b1, 1'b0); run(1, 1'b0, 8, "add_7f_cin");
      @(negedge clk);
      push_op(8'h10, 8'h20, 1'b1, 1'b1); run(1, 1'b0, 8, "sub_10_20");
      @(negedge clk);
      push_op(8'h80, 8'h01, 1'b1, 1'b1); run(1, 1'b0, 8, "sub_80_01");
      @(negedge clk);
      push_op(8'h33, 8'h11, 1'b0, 1'b0); run(3, 1'b1, 24, "stall_33_11");
      @(negedge clk);
      hold = 1'b1;
      push_op(8'h12, 8'h34, 1'b0, 1'b0); run(1, 1'b0, 8, "b2b_first");
      push_op(8'h55, 8'h22, 1'b0, 1'b0); run(1, 1'b0, 8, "b2b_second");
      push_op(8'h0F, 8'h01, 1'b0, 1'b0);
      @(negedge clk);
      hold = 1'b0;
      u.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(q.pop_back());
      last_sum = 8'h00;
      chk("abort sum", 32'(u.sum), 0);
      chk("abort cout", 32'(u.cout), 0);
      chk("abort ovf", 32'(u.ovf), 0);
      chk("abort busy", 32'(u.busy), 0);
      chk("abort done", 32'(u.done), 0);
      repeat (12) begin
         @(negedge clk);
         if (u.done) nd = 1'b1;
      end
      chk("abort no_done_pulse", 32'(nd), 0);
      push_op(8'hA0, 8'h60, 1'b0, 1'b0); run(1, 1'b0, 8, "post_reset");
      @(negedge clk);
      u3.a = 3'd7; u3.b = 3'd1; u3.cin = 1'b1; u3.sub = 1'b0; u3.start = 1'b1;
      @(negedge clk);
      u3.start = 1'b0;
      for (int c = 1; c <= 20 && !g3; c++) begin
         @(negedge clk);
         if (u3.done) begin
            g3 = 1'b1;
            cyc3 = c;
         end
      end
      chk("w3 done_seen", 32'(g3), 1);
      chk("w3 latency", 32'(cyc3), 3);
      chk("w3 sum", 32'(u3.sum), 1);
      chk("w3 cout", 32'(u3.cout), 1);
      chk("w3 ovf", 32'(u3.ovf), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
